// File: rtl/if_inst_bridge.sv
// Instruction-fetch bridge: turns IF-stage PC requests into a single outstanding
// SRAM-like req/addr_ok/data_ok transaction and hands the word back to IF/ID.
module if_inst_bridge #(
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0000,
    parameter bit          USE_KSEG_MAP = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] if_pc_i,
    input  logic        if_req_i,
    input  logic        flush_i,
    input  logic        pipe_stall_i,
    output logic [31:0] if_instr_o,
    output logic        if_instr_valid_o,
    output logic        if_stall_req_o,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic [31:0] inst_rdata_i,
    input  logic        inst_data_ok_i
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

    state_t      state;
    logic        cancel_q;
    logic [31:0] addr_q;
    logic [31:0] buf_q;

    logic        mis;
    logic        req_idle;
    logic [31:0] pc_phys;

    logic [31:0] instr_c;
    logic        valid_c;
    logic        stall_c;
    logic        req_c;
    logic [31:0] addr_c;

    function automatic logic [31:0] map_addr(input logic [31:0] a);
        if (USE_KSEG_MAP && a[31:30] == 2'b10)
            return {3'b000, a[28:0]};
        return a;
    endfunction

    assign mis      = (if_pc_i[1:0] != 2'b00);
    assign req_idle = if_req_i & ~mis & ~flush_i;
    assign pc_phys  = map_addr(if_pc_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cancel_q <= 1'b0;
            addr_q   <= 32'h0;
            buf_q    <= NOP_INSTR;
        end else begin
            case (state)
                IDLE: begin
                    if (req_idle) begin
                        addr_q <= pc_phys;
                        state  <= inst_addr_ok_i ? DATA : ADDR;
                    end
                end
                ADDR: begin
                    // The request stays up through a flush; only the reply is discarded.
                    if (flush_i)
                        cancel_q <= 1'b1;
                    if (inst_addr_ok_i)
                        state <= DATA;
                end
                DATA: begin
                    if (inst_data_ok_i) begin
                        cancel_q <= 1'b0;
                        if (!cancel_q && !flush_i && pipe_stall_i) begin
                            buf_q <= inst_rdata_i;
                            state <= HOLD;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (flush_i) begin
                        cancel_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (flush_i || !pipe_stall_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        instr_c = NOP_INSTR;
        valid_c = 1'b0;
        stall_c = 1'b0;
        req_c   = 1'b0;
        addr_c  = addr_q;
        case (state)
            IDLE: begin
                req_c   = req_idle;
                addr_c  = pc_phys;
                stall_c = req_idle;
            end
            ADDR: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
            end
            DATA: begin
                if (inst_data_ok_i) begin
                    if (!cancel_q && !flush_i) begin
                        instr_c = inst_rdata_i;
                        valid_c = 1'b1;
                    end
                end else begin
                    stall_c = 1'b1;
                end
            end
            HOLD: begin
                if (!flush_i) begin
                    instr_c = buf_q;
                    valid_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Outputs read idle for as long as reset is held, independent of the inputs.
    assign if_instr_o       = rst_i ? NOP_INSTR : instr_c;
    assign if_instr_valid_o = ~rst_i & valid_c;
    assign if_stall_req_o   = ~rst_i & stall_c;
    assign inst_req_o       = ~rst_i & req_c;
    assign inst_addr_o      = rst_i ? 32'h0 : addr_c;

endmodule

// File: tb/tb_if_inst_bridge.sv
// Directed bench for if_inst_bridge: inputs change 1ns after posedge, outputs
// are checked 1ns later, well before the next rising edge.
module tb_if_inst_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] if_pc_i;
    logic        if_req_i;
    logic        flush_i;
    logic        pipe_stall_i;
    logic [31:0] if_instr_o;
    logic        if_instr_valid_o;
    logic        if_stall_req_o;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_addr_ok_i;
    logic [31:0] inst_rdata_i;
    logic        inst_data_ok_i;

    int tests = 0;
    int fails = 0;

    if_inst_bridge dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .if_pc_i          (if_pc_i),
        .if_req_i         (if_req_i),
        .flush_i          (flush_i),
        .pipe_stall_i     (pipe_stall_i),
        .if_instr_o       (if_instr_o),
        .if_instr_valid_o (if_instr_valid_o),
        .if_stall_req_o   (if_stall_req_o),
        .inst_req_o       (inst_req_o),
        .inst_addr_o      (inst_addr_o),
        .inst_addr_ok_i   (inst_addr_ok_i),
        .inst_rdata_i     (inst_rdata_i),
        .inst_data_ok_i   (inst_data_ok_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] instr, input logic valid,
                           input logic stall, input logic req);
        chk({tag, ".instr"}, if_instr_o, instr);
        chk({tag, ".valid"}, {31'b0, if_instr_valid_o}, {31'b0, valid});
        chk({tag, ".stall"}, {31'b0, if_stall_req_o}, {31'b0, stall});
        chk({tag, ".req"}, {31'b0, inst_req_o}, {31'b0, req});
    endtask

    task automatic bus(input logic aok, input logic dok, input logic [31:0] rd);
        inst_addr_ok_i = aok;
        inst_data_ok_i = dok;
        inst_rdata_i   = rd;
    endtask

    initial begin
        rst_i = 1'b1; if_pc_i = 32'h0; if_req_i = 1'b0; flush_i = 1'b0;
        pipe_stall_i = 1'b0; bus(1'b0, 1'b0, 32'h0);
        settle();
        chk_out("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        chk("reset.addr", inst_addr_o, 32'h0);
        tick(); tick();
        rst_i = 1'b0;

        // zero-wait fetch with kseg1 mapping
        if_pc_i = 32'hBFC0_0000; if_req_i = 1'b1; bus(1'b1, 1'b0, 32'h0);
        settle();
        chk_out("zw.req", 32'h0, 1'b0, 1'b1, 1'b1);
        chk("zw.addr", inst_addr_o, 32'h1FC0_0000);
        tick();
        bus(1'b0, 1'b1, 32'h2408_0001);
        settle();
        chk_out("zw.data", 32'h2408_0001, 1'b1, 1'b0, 1'b0);
        tick();
        if_req_i = 1'b0; bus(1'b0, 1'b0, 32'hFFFF_FFFF);
        settle();
        chk_out("zw.idle", 32'h0, 1'b0, 1'b0, 1'b0);

        // addr_ok after 3 extra cycles, two data wait cycles
        if_pc_i = 32'hBFC0_0004; if_req_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus(i == 3, 1'b0, 32'h0);
            settle();
            chk_out($sformatf("slow.a%0d", i), 32'h0, 1'b0, 1'b1, 1'b1);
            chk($sformatf("slow.addr%0d", i), inst_addr_o, 32'h1FC0_0004);
            if (i == 1) if_pc_i = 32'hBFC0_0004;
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            bus(1'b0, 1'b0, 32'h0);
            settle();
            chk_out($sformatf("slow.w%0d", i), 32'h0, 1'b0, 1'b1, 1'b0);
            tick();
        end
        bus(1'b0, 1'b1, 32'h0000_0042);
        settle();
        chk_out("slow.data", 32'h0000_0042, 1'b1, 1'b0, 1'b0);
        tick();
        if_req_i = 1'b0; bus(1'b0, 1'b0, 32'h0);
        settle();
        chk_out("slow.idle", 32'h0, 1'b0, 1'b0, 1'b0);

        // word returned under pipeline stall is held in the buffer
        if_pc_i = 32'hBFC0_0008; if_req_i = 1'b1; bus(1'b1, 1'b0, 32'h0);
        tick();
        pipe_stall_i = 1'b1; bus(1'b0, 1'b1, 32'h0000_000C);
        settle();
        chk_out("hold.d", 32'h0000_000C, 1'b1, 1'b0, 1'b0);
        tick();
        bus(1'b0, 1'b0, 32'hDEAD_BEEF);
        for (int i = 0; i < 2; i++) begin
            settle();
            chk_out($sformatf("hold.h%0d", i), 32'h0000_000C, 1'b1, 1'b0, 1'b0);
            tick();
        end
        pipe_stall_i = 1'b0;
        settle();
        chk_out("hold.last", 32'h0000_000C, 1'b1, 1'b0, 1'b0);
        tick();
        if_req_i = 1'b0;
        settle();
        chk_out("hold.idle", 32'h0, 1'b0, 1'b0, 1'b0);

        // flush while waiting for data: the late word is dropped
        if_pc_i = 32'hBFC0_0010; if_req_i = 1'b1; bus(1'b1, 1'b0, 32'h0);
        tick();
        bus(1'b0, 1'b0, 32'h0); flush_i = 1'b1;
        settle();
        chk_out("fl.flush", 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        flush_i = 1'b0; if_pc_i = 32'hBFC0_0380;
        settle();
        chk_out("fl.wait", 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        bus(1'b0, 1'b1, 32'h1234_5678);
        settle();
        chk("fl.drop.valid", {31'b0, if_instr_valid_o}, 32'h0);
        chk("fl.drop.instr", if_instr_o, 32'h0);
        tick();
        bus(1'b1, 1'b0, 32'h0);
        settle();
        chk_out("fl.next", 32'h0, 1'b0, 1'b1, 1'b1);
        chk("fl.next.addr", inst_addr_o, 32'h1FC0_0380);
        tick();
        bus(1'b0, 1'b1, 32'hAAAA_0001);
        settle();
        chk_out("fl.next.data", 32'hAAAA_0001, 1'b1, 1'b0, 1'b0);
        tick();
        bus(1'b0, 1'b0, 32'h0);

        // misaligned PC: no bus activity, no stall
        if_pc_i = 32'h8000_0002; if_req_i = 1'b1;
        settle();
        chk_out("mis", 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("mis.next", 32'h0, 1'b0, 1'b0, 1'b0);

        // mapping boundaries, observed combinationally in IDLE
        if_pc_i = 32'hC000_0000; settle();
        chk("map.c0", inst_addr_o, 32'hC000_0000);
        if_pc_i = 32'h7FFF_FFFC; settle();
        chk("map.7f", inst_addr_o, 32'h7FFF_FFFC);
        if_pc_i = 32'h8000_0000; settle();
        chk("map.80", inst_addr_o, 32'h0000_0000);
        if_req_i = 1'b0;
        tick();

        // flush coincident with addr_ok: goes to DATA with the reply cancelled
        if_pc_i = 32'hA000_1000; if_req_i = 1'b1; bus(1'b0, 1'b0, 32'h0);
        tick();
        flush_i = 1'b1; bus(1'b1, 1'b0, 32'h0);
        settle();
        chk_out("fa.addr", 32'h0, 1'b0, 1'b1, 1'b1);
        chk("fa.addrv", inst_addr_o, 32'h0000_1000);
        tick();
        flush_i = 1'b0; bus(1'b0, 1'b1, 32'h0000_0005);
        settle();
        chk_out("fa.drop", 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        if_req_i = 1'b0; bus(1'b0, 1'b0, 32'h0);
        settle();
        chk_out("fa.idle", 32'h0, 1'b0, 1'b0, 1'b0);

        // flush coincident with an uncancelled data_ok, and flush in HOLD
        if_pc_i = 32'h0000_0100; if_req_i = 1'b1; bus(1'b1, 1'b0, 32'h0);
        tick();
        flush_i = 1'b1; bus(1'b0, 1'b1, 32'h0000_0077);
        settle();
        chk_out("fd.drop", 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        flush_i = 1'b0; bus(1'b1, 1'b0, 32'h0);
        settle();
        chk_out("fd.idle", 32'h0, 1'b0, 1'b1, 1'b1);
        tick();
        pipe_stall_i = 1'b1; bus(1'b0, 1'b1, 32'h0000_0088);
        tick();
        flush_i = 1'b1; bus(1'b0, 1'b0, 32'h0);
        settle();
        chk_out("fh.flush", 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        flush_i = 1'b0; if_req_i = 1'b0;
        settle();
        chk_out("fh.idle", 32'h0, 1'b0, 1'b0, 1'b0);
        pipe_stall_i = 1'b0;

        // asynchronous reset while in ADDR, then a fresh fetch
        if_pc_i = 32'hBFC0_0020; if_req_i = 1'b1; bus(1'b0, 1'b0, 32'h0);
        tick();
        settle();
        chk_out("rs.addr", 32'h0, 1'b0, 1'b1, 1'b1);
        #2 rst_i = 1'b1;
        #1;
        chk_out("rs.async", 32'h0, 1'b0, 1'b0, 1'b0);
        chk("rs.addrv", inst_addr_o, 32'h0);
        tick();
        rst_i = 1'b0; if_pc_i = 32'hBFC0_0024; bus(1'b1, 1'b0, 32'h0);
        settle();
        chk_out("rs.fresh", 32'h0, 1'b0, 1'b1, 1'b1);
        chk("rs.fresh.addr", inst_addr_o, 32'h1FC0_0024);
        tick();
        bus(1'b0, 1'b1, 32'h3C1D_0000);
        settle();
        chk_out("rs.data", 32'h3C1D_0000, 1'b1, 1'b0, 1'b0);
        tick();
        if_req_i = 1'b0; bus(1'b0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_inst_bridge.md
Name: if_inst_bridge

Overview:
- Responder side of the instruction-fetch path. Accepts the fetch PC from the IF stage and runs an SRAM-like request/address-ok/data-ok transaction toward instruction memory.
- Returns the fetched instruction to IF/ID. Raises a stall request until the word for the current PC is delivered.
- Handles pipeline stall (buffers the returned word) and flush (drops the in-flight response). At most one outstanding transaction.

Parameters:
- NOP_INSTR, 32'h0000_0000, instruction driven when no valid fetch data (misaligned PC, flush, idle).
- USE_KSEG_MAP, 1, when 1: virtual 0x8000_0000–0xBFFF_FFFF is mapped to physical by clearing addr[31:29]; other addresses pass unchanged.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- if_pc_i  in  32  fetch PC from IF
- if_req_i  in  1  IF wants the word at if_pc_i
- flush_i  in  1  exception/redirect flush
- pipe_stall_i  in  1  downstream stall (from any source other than this block)
- if_instr_o  out  32  instruction to IF/ID
- if_instr_valid_o  out  1  if_instr_o is the word for current PC
- if_stall_req_o  out  1  fetch not complete; freeze PC and pipeline front
- inst_req_o  out  1  bus request
- inst_addr_o  out  32  bus physical address
- inst_addr_ok_i  in  1  slave accepted address
- inst_rdata_i  in  32  bus read data
- inst_data_ok_i  in  1  read data valid

Behaviour:
- Reset (asynchronous, rst_i=1): state=IDLE; cancel_q=0; addr_q=0; buf_q=NOP_INSTR. All outputs read 0, with if_instr_o=NOP_INSTR. Reset mid-transaction abandons it; the slave is reset by the same rst_i.
- Misaligned: mis = if_pc_i[1:0]!=0. No bus request is issued. if_instr_o=NOP_INSTR, valid=0, stall_req=0. The exception is flagged by IF.
- FSM states: IDLE, ADDR, DATA, HOLD.
- IDLE:
  - inst_req_o = if_req_i & ~mis & ~flush_i; inst_addr_o = map(if_pc_i).
  - If req & addr_ok → DATA. If req & ~addr_ok → ADDR. In both cases addr_q ← map(if_pc_i).
  - stall_req = inst_req_o.
- ADDR:
  - inst_req_o=1, inst_addr_o=addr_q; both are held stable until addr_ok. A request is never withdrawn, even on flush.
  - addr_ok → DATA. stall_req=1.
- DATA:
  - inst_req_o=0. Wait for data_ok.
  - On data_ok & ~cancel_q: if_instr_o=inst_rdata_i (combinational pass-through), valid=1, stall_req=0. Then:
    - pipe_stall_i=0 → IDLE.
    - pipe_stall_i=1 → buf_q ← rdata, go to HOLD.
  - On data_ok & cancel_q: drop the data, cancel_q←0, → IDLE, valid=0.
  - stall_req=1 while waiting.
- HOLD:
  - if_instr_o=buf_q, valid=1, stall_req=0.
  - pipe_stall_i=0 → IDLE (word consumed this cycle).
- Flush:
  - In ADDR or DATA (not coincident with an uncancelled data_ok): cancel_q←1.
  - In HOLD: → IDLE, buffer discarded, valid=0.
  - In IDLE: suppresses the request.
  - While cancel_q=1: valid=0 and stall_req=1 until the cancelled data_ok arrives.
- Simultaneous events:
  - flush_i and data_ok in DATA with cancel_q=0: data is dropped, → IDLE.
  - flush_i with addr_ok in ADDR: → DATA with cancel_q=1.
- Latency:
  - Zero-wait slave (addr_ok same cycle, data_ok next cycle): word valid 1 cycle after the request cycle.
  - Throughput is one fetch per 2 cycles (IDLE→DATA→IDLE); no pipelined requests.
- Mapping: map(a) = (USE_KSEG_MAP && a[31:30]==2'b10) ? {3'b000,a[28:0]} : a.

Test Plan:
- Zero-wait slave, pc=0xBFC0_0000 → inst_addr_o=0x1FC0_0000, req 1 cycle. Next cycle data_ok with rdata=0x2408_0001 → if_instr_o=0x2408_0001, valid=1, stall_req=0; back to IDLE.
- addr_ok delayed 3 cycles, data_ok delayed 2 → inst_req_o held 4 cycles with constant address; stall_req high 6 cycles; valid pulses once.
- data_ok with rdata=0x0000_000C while pipe_stall_i=1 for 3 cycles → if_instr_o=0x0000_000C, valid held 4 cycles; IDLE after pipe_stall_i drops.
- flush_i in DATA, data_ok 2 cycles later with rdata=0x1234_5678 → valid never asserts; stall_req=1 until data_ok, then next pc 0xBFC0_0380 is fetched.
- pc=0x8000_0002 with if_req_i=1 → inst_req_o=0, if_instr_o=NOP_INSTR, stall_req=0.
- rst_i asserted in ADDR state → all outputs 0 asynchronously; state IDLE; after release, a fresh fetch completes normally.
